// File: rtl/a5_key_sched_if.sv
// Control, setup and keystream handshake bundle for the A5/1 key scheduler.
// The master side issues requests and accepts bits; the slave side is the core.
interface a5_key_sched_if;
    logic        start;
    logic        abort;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        ks_valid;
    logic        ks_ready;
    logic        ks_bit;
    logic        done;

    modport master (
        output start, abort, key, frame, ks_ready,
        input  busy, ks_valid, ks_bit, done
    );

    modport slave (
        input  start, abort, key, frame, ks_ready,
        output busy, ks_valid, ks_bit, done
    );
endinterface

// File: rtl/a5_key_sched.sv
// A5/1 keystream core: loads key and frame, runs the majority-clocked mixing phase,
// then emits one keystream bit per ready/valid handshake.
module a5_key_sched #(
    parameter int unsigned NUM_BITS   = 228,
    parameter int unsigned MIX_CYCLES = 100
) (
    input  logic          clk,
    input  logic          reset,
    a5_key_sched_if.slave io
);
    localparam logic [7:0] KEY_LAST   = 8'd63;
    localparam logic [7:0] FRAME_LAST = 8'd21;
    localparam logic [7:0] MIX_LAST   = 8'(MIX_CYCLES);
    localparam logic [9:0] OUT_LAST   = 10'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [63:0] key_sh;
    logic [21:0] frame_sh;
    // Eight bits so the mix phase can count to MIX_CYCLES=255 without wrapping.
    logic [7:0]  setup_cnt;
    logic [9:0]  out_cnt;
    logic        done_q;

    logic latch;
    logic clear;
    logic load_en;
    logic maj_en;
    logic in_bit;
    logic setup_inc;
    logic setup_clr;
    logic out_inc;
    logic done_nxt;

    logic fb1;
    logic fb2;
    logic fb3;
    logic maj;

    assign fb1 = r1[18] ^ r1[17] ^ r1[16] ^ r1[13];
    assign fb2 = r2[21] ^ r2[20];
    assign fb3 = r3[22] ^ r3[21] ^ r3[20] ^ r3[7];
    assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        clear     = 1'b0;
        load_en   = 1'b0;
        maj_en    = 1'b0;
        in_bit    = 1'b0;
        setup_inc = 1'b0;
        setup_clr = 1'b0;
        out_inc   = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (io.start) begin
                    latch     = 1'b1;
                    clear     = 1'b1;
                    state_nxt = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                load_en = 1'b1;
                in_bit  = key_sh[0];
                if (setup_cnt == KEY_LAST) begin
                    setup_clr = 1'b1;
                    state_nxt = LOAD_FRAME;
                end else begin
                    setup_inc = 1'b1;
                end
            end
            LOAD_FRAME: begin
                load_en = 1'b1;
                in_bit  = frame_sh[0];
                if (setup_cnt == FRAME_LAST) begin
                    setup_clr = 1'b1;
                    state_nxt = MIX;
                end else begin
                    setup_inc = 1'b1;
                end
            end
            MIX: begin
                maj_en = 1'b1;
                if (setup_cnt == MIX_LAST) begin
                    setup_clr = 1'b1;
                    state_nxt = RUN;
                end else begin
                    setup_inc = 1'b1;
                end
            end
            RUN: begin
                if (io.ks_ready) begin
                    maj_en = 1'b1;
                    if (out_cnt == OUT_LAST) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        out_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything, including a start seen in IDLE.
        if (io.abort) begin
            state_nxt = IDLE;
            latch     = 1'b0;
            clear     = 1'b1;
            load_en   = 1'b0;
            maj_en    = 1'b0;
            setup_inc = 1'b0;
            setup_clr = 1'b1;
            out_inc   = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            key_sh    <= '0;
            frame_sh  <= '0;
            setup_cnt <= '0;
            out_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            if (latch) begin
                key_sh   <= io.key;
                frame_sh <= io.frame;
            end else if (load_en) begin
                if (state == LOAD_KEY) begin
                    key_sh <= key_sh >> 1;
                end else begin
                    frame_sh <= frame_sh >> 1;
                end
            end

            if (clear) begin
                r1 <= '0;
                r2 <= '0;
                r3 <= '0;
            end else if (load_en) begin
                r1 <= {r1[17:0], fb1 ^ in_bit};
                r2 <= {r2[20:0], fb2 ^ in_bit};
                r3 <= {r3[21:0], fb3 ^ in_bit};
            end else if (maj_en) begin
                if (r1[8] == maj) r1 <= {r1[17:0], fb1};
                if (r2[10] == maj) r2 <= {r2[20:0], fb2};
                if (r3[10] == maj) r3 <= {r3[21:0], fb3};
            end

            if (clear || setup_clr) begin
                setup_cnt <= '0;
            end else if (setup_inc) begin
                setup_cnt <= setup_cnt + 8'd1;
            end

            if (clear || done_nxt) begin
                out_cnt <= '0;
            end else if (out_inc) begin
                out_cnt <= out_cnt + 10'd1;
            end

            done_q <= done_nxt;
        end
    end

    assign io.busy     = (state != IDLE);
    assign io.ks_valid = (state == RUN);
    assign io.ks_bit   = r1[18] ^ r2[21] ^ r3[22];
    assign io.done     = done_q;
endmodule
